systolic_gemm: RTL
==================

# systolic_gemm

Parametrised output-stationary systolic matrix-multiply engine: a ROWS×COLS grid of signed multiply-accumulate cells. Internal input skew and a control FSM are built in, so operands are streamed unskewed through a valid/ready handshake. Results are drained row by row through a second valid/ready port. It is the next generation of the fixed-N square array: it supports rectangular grids, runtime inner dimension, bubble tolerance, backpressure and optional saturating accumulation.

## Interface
- D_W, 8: operand width, signed two's complement
- ROWS, 4: grid rows (number of A rows / C rows), ≥1
- COLS, 4: grid columns (number of B columns / C columns), ≥1
- ACC_W, 24: accumulator width, ≥2*D_W
- K_W, 8: width of k_len
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  begin a job; honoured only in IDLE
- k_len  in  K_W  inner dimension K, sampled with start
- busy  out  1  high in any state except IDLE
- in_valid  in  1  operand beat valid
- in_ready  out  1  high only in LOAD
- a_data  in  ROWS*D_W  A column k; element r at [r*D_W +: D_W]
- b_data  in  COLS*D_W  B row k; element c at [c*D_W +: D_W]
- out_valid  out  1  result row valid
- out_ready  in  1  sink accepts result row
- out_data  out  COLS*ACC_W  C row; element c at [c*ACC_W +: ACC_W]
- out_row  out  $clog2(ROWS) (min 1)  index of presented row
- out_last  out  1  high with row ROWS-1
- done  out  1  one-cycle pulse after last row accepted
- sat_flag  out  1  sticky saturation indicator for current job

## Operation
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE with start=1:
  - latch K=k_len;
  - clear all accumulators, skew registers, cell pipeline registers and sat_flag;
  - go to LOAD if K>0, else DRAIN.
- LOAD:
  - each accepted beat (in_valid && in_ready) counts toward K;
  - on the K-th accepted beat, go to FLUSH.
- Skew: a_data element r is delayed r cycles; b_data element c is delayed c cycles.
  - When no beat is accepted, zeros are injected; bubbles add nothing.
  - In FLUSH and DRAIN, zeros are injected every cycle.
- Cell (r,c), every cycle:
  - acc += a_in*b_in, where the 2*D_W signed product is sign-extended to ACC_W;
  - a is registered rightward to (r,c+1);
  - b is registered downward to (r+1,c).
- FLUSH: lasts exactly ROWS+COLS-1 cycles, then DRAIN.
- DRAIN:
  - out_valid=1; out_data holds row out_row, starting at row 0;
  - row advances on out_valid && out_ready;
  - out_data and out_row stay stable while out_ready=0;
  - the handshake on row ROWS-1 (out_last=1) returns the FSM to IDLE, and done=1 the following cycle.
- Result: C[r][c] = Σ_k A[r][k]*B[k][c] over the K accepted beats.
- start outside IDLE is ignored. in_valid outside LOAD is ignored. sat_flag holds until the next accepted start.
- Reset (rst=0 at a clock edge), including mid-job:
  - FSM to IDLE;
  - all accumulators, skew and pipeline registers to 0.

## Timing
- Reset values: busy=0, in_ready=0, out_valid=0, out_data=0, out_row=0, out_last=0, done=0, sat_flag=0.
- Cycle 0: start is accepted. Cycle 1: LOAD, in_ready=1.
- With in_valid held high, the last beat is accepted at cycle K. FLUSH runs over cycles K+1 … K+ROWS+COLS-1. First out_valid is at cycle K+ROWS+COLS.
- K=0: DRAIN at cycle 1, and all rows are 0.
- With out_ready held high, the drain takes ROWS cycles and done follows 1 cycle after the last handshake.
- Back-to-back jobs: a start in the same cycle as done is accepted.

## Configuration
- SYSTOLIC_SAT_EN defined:
  - each accumulate clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1];
  - any clamp sets sat_flag.
- Not defined:
  - accumulation wraps modulo 2^ACC_W;
  - sat_flag is tied to 0.

## Test plan
- Defaults, K=4, A=I4, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, in_valid=1, out_ready=1 -> rows 0..3 equal B rows; out_last on row 3; done 1 cycle later; first out_valid at cycle 12.
- Same job with in_valid toggling 1/0 every cycle -> identical outputs; first out_valid delayed by the 3 bubbles beyond cycle 12.
- K=2, all a=-128, all b=127 -> every C element = -32512.
- ACC_W=16, K=3, all a=b=-128:
  - without macro -> -16384, sat_flag=0;
  - with SYSTOLIC_SAT_EN -> 32767, sat_flag=1.
- During DRAIN, out_ready=0 for 5 cycles on row 1 -> out_data and out_row stay constant; rows still arrive in order 0..3.
- rst=0 mid-LOAD, then start with K=0 -> all four rows 0, done pulses; then start with K=1, a=all 3, b=all -2 -> all C elements = -6.

Source files
------------

// File: rtl/systolic_gemm.sv
// Output-stationary ROWS x COLS signed MAC grid with built-in operand skew and row-wise drain.
// Define SYSTOLIC_SAT_EN for saturating accumulation; otherwise accumulators wrap.
module systolic_gemm #(
  parameter int unsigned D_W   = 8,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned K_W   = 8,
  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [K_W-1:0]        k_len,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*D_W-1:0]   a_data,
  input  logic [COLS*D_W-1:0]   b_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COLS*ACC_W-1:0] out_data,
  output logic [RW-1:0]         out_row,
  output logic                  out_last,
  output logic                  done,
  output logic                  sat_flag
);

  localparam int unsigned FL_N = ROWS + COLS - 1;
  localparam int unsigned FC_W = $clog2(ROWS + COLS) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]             state, state_nx;
  logic [K_W-1:0]         k_reg, k_cnt;
  logic [FC_W-1:0]        f_cnt;
  logic [RW-1:0]          row_nx;
  logic                   clr, accept, last_hs;
  logic [COLS*ACC_W-1:0]  out_nx;

  logic signed [D_W-1:0]   a_w [ROWS][COLS];
  logic signed [D_W-1:0]   b_w [ROWS][COLS];
  logic signed [ACC_W-1:0] acc [ROWS][COLS];

  // Next-state and handshake decode
  always_comb begin
    state_nx = state;
    row_nx   = out_row;
    clr      = 1'b0;
    accept   = 1'b0;
    last_hs  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          clr      = 1'b1;
          row_nx   = '0;
          state_nx = (k_len != '0) ? S_LOAD : S_DRAIN;
        end
      end
      S_LOAD: begin
        accept = in_valid;
        if (in_valid && (k_cnt == k_reg - K_W'(1))) state_nx = S_FLUSH;
      end
      S_FLUSH: begin
        if (f_cnt == FC_W'(FL_N - 1)) state_nx = S_DRAIN;
      end
      default: begin
        if (out_ready) begin
          if (out_row == RW'(ROWS - 1)) begin
            last_hs  = 1'b1;
            row_nx   = '0;
            state_nx = S_IDLE;
          end else begin
            row_nx = out_row + RW'(1);
          end
        end
      end
    endcase
  end

  // Results are final once FLUSH ends, so the next presented row can be read straight from acc
  always_comb begin
    out_nx = '0;
    if (state_nx == S_DRAIN && !clr) begin
      for (int c = 0; c < COLS; c++) out_nx[c*ACC_W +: ACC_W] = acc[row_nx][c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      k_reg     <= '0;
      k_cnt     <= '0;
      f_cnt     <= '0;
      out_row   <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nx;
      out_row   <= row_nx;
      busy      <= (state_nx != S_IDLE);
      in_ready  <= (state_nx == S_LOAD);
      out_valid <= (state_nx == S_DRAIN);
      out_last  <= (state_nx == S_DRAIN) && (row_nx == RW'(ROWS - 1));
      done      <= last_hs;
      out_data  <= out_nx;
      if (clr) begin
        k_reg <= k_len;
        k_cnt <= '0;
      end else if (accept) begin
        k_cnt <= k_cnt + K_W'(1);
      end
      f_cnt <= (state == S_FLUSH) ? f_cnt + FC_W'(1) : '0;
    end
  end

  // Row r of A is delayed r cycles before entering the grid
  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    if (r == 0) begin : g_d0
      assign a_w[0][0] = accept ? a_data[0 +: D_W] : '0;
    end else begin : g_dn
      logic signed [D_W-1:0] sk [r];
      always_ff @(posedge clk) begin
        if (!rst || clr) begin
          for (int i = 0; i < r; i++) sk[i] <= '0;
        end else begin
          sk[0] <= accept ? a_data[r*D_W +: D_W] : '0;
          for (int i = 1; i < r; i++) sk[i] <= sk[i-1];
        end
      end
      assign a_w[r][0] = sk[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    if (c == 0) begin : g_d0
      assign b_w[0][0] = accept ? b_data[0 +: D_W] : '0;
    end else begin : g_dn
      logic signed [D_W-1:0] sk [c];
      always_ff @(posedge clk) begin
        if (!rst || clr) begin
          for (int i = 0; i < c; i++) sk[i] <= '0;
        end else begin
          sk[0] <= accept ? b_data[c*D_W +: D_W] : '0;
          for (int i = 1; i < c; i++) sk[i] <= sk[i-1];
        end
      end
      assign b_w[0][c] = sk[c-1];
    end
  end

`ifdef SYSTOLIC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic [ROWS*COLS-1:0] clamp;
`endif

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic signed [2*D_W-1:0] prod;
      logic signed [ACC_W-1:0] acc_q, acc_nx;

      assign prod = (2*D_W)'(a_w[r][c]) * (2*D_W)'(b_w[r][c]);
`ifdef SYSTOLIC_SAT_EN
      logic signed [ACC_W:0] sum;
      logic                  ovf;
      assign sum    = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod);
      assign ovf    = sum[ACC_W] ^ sum[ACC_W-1];
      assign acc_nx = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
      assign clamp[r*COLS+c] = ovf;
`else
      assign acc_nx = acc_q + ACC_W'(prod);
`endif

      always_ff @(posedge clk) begin
        if (!rst || clr) acc_q <= '0;
        else             acc_q <= acc_nx;
      end
      assign acc[r][c] = acc_q;

      // Operands hop one cell right (a) and one cell down (b) per cycle
      if (c < COLS - 1) begin : g_apipe
        logic signed [D_W-1:0] a_q;
        always_ff @(posedge clk) begin
          if (!rst || clr) a_q <= '0;
          else             a_q <= a_w[r][c];
        end
        assign a_w[r][c+1] = a_q;
      end
      if (r < ROWS - 1) begin : g_bpipe
        logic signed [D_W-1:0] b_q;
        always_ff @(posedge clk) begin
          if (!rst || clr) b_q <= '0;
          else             b_q <= b_w[r][c];
        end
        assign b_w[r+1][c] = b_q;
      end
    end
  end

`ifdef SYSTOLIC_SAT_EN
  always_ff @(posedge clk) begin
    if (!rst || clr)  sat_flag <= 1'b0;
    else if (|clamp)  sat_flag <= 1'b1;
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule
